// File: rtl/mc_state_sequencer.sv
// Registered sequencing stage of the multicycle CPU: state register, IR and PC,
// plus memory-wait stalling, retired-instruction and stall-cycle counters.
module mc_state_sequencer #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        ns,
  input  logic              pcw,
  input  logic              pcwc,
  input  logic [1:0]        pcs,
  input  logic              irw,
  input  logic              mr,
  input  logic              mw,
  input  logic              mem_ready,
  input  logic              zero,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [3:0]        s,
  output logic [5:0]        op,
  output logic [WIDTH-1:0]  ir,
  output logic [WIDTH-1:0]  pc,
  output logic              stall,
  output logic [31:0]       instret,
  output logic [15:0]       stall_cnt,
  output logic              bad_state
);

  // state      | meaning
  // S_FETCH    | fetch instruction, PC+4
  // S_DECODE   | decode, register read, branch target
  // S_MEMADDR  | load/store address computation
  // S_MEMREAD  | load memory access
  // S_WRITEBACK| load register writeback
  // S_MEMWRITE | store memory access
  // S_EXECUTE  | R-type ALU operation
  // S_RCOMPLETE| R-type register writeback
  // S_BRANCH   | branch compare and conditional PC write
  // S_JUMP     | jump target PC write
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADDR   = 4'd2,
    S_MEMREAD   = 4'd3,
    S_WRITEBACK = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTE   = 4'd6,
    S_RCOMPLETE = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             ns_legal;
  logic             pc_en;
  logic             pc_write;
  logic [WIDTH-1:0] pc_next;

  assign stall    = (mr | mw) & ~mem_ready;
  assign pc_en    = pcw | (pcwc & zero);
  assign pc_write = pc_en & (pcs != 2'b11);
  assign ns_legal = (ns <= 4'd9);
  assign s        = state;
  assign op       = ir[31:26];

  always_comb begin
    next_state = S_FETCH;
    if (ns_legal) next_state = state_t'(ns);
  end

  // Jump target is formed from the pre-edge PC and IR.
  always_comb begin
    pc_next = alu_result;
    case (pcs)
      2'b00:   pc_next = alu_result;
      2'b01:   pc_next = alu_out;
      2'b10:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      ir        <= '0;
      pc        <= RESET_PC;
      instret   <= '0;
      stall_cnt <= '0;
      bad_state <= 1'b0;
    end else if (stall) begin
      if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end else begin
      state <= next_state;
      if (!ns_legal) bad_state <= 1'b1;
      if (irw) ir <= mem_rdata;
      if (pc_write) pc <= pc_next;
      if (state != S_FETCH && next_state == S_FETCH) instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_mc_state_sequencer.sv
// Directed testbench for mc_state_sequencer with immediate-assertion checks.
module tb_mc_state_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ns;
  logic        pcw, pcwc, irw, mr, mw, mem_ready, zero;
  logic [1:0]  pcs;
  logic [31:0] alu_result, alu_out, mem_rdata;
  logic [3:0]  s;
  logic [5:0]  op;
  logic [31:0] ir, pc, instret;
  logic        stall, bad_state;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  mc_state_sequencer #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .ns(ns), .pcw(pcw), .pcwc(pcwc), .pcs(pcs),
    .irw(irw), .mr(mr), .mw(mw), .mem_ready(mem_ready), .zero(zero),
    .alu_result(alu_result), .alu_out(alu_out), .mem_rdata(mem_rdata),
    .s(s), .op(op), .ir(ir), .pc(pc), .stall(stall), .instret(instret),
    .stall_cnt(stall_cnt), .bad_state(bad_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    pcw = 0; pcwc = 0; irw = 0; mr = 0; mw = 0; mem_ready = 0; zero = 0; pcs = 2'b00;
  endtask

  initial begin
    reset = 1; ns = 0; idle_ctrl();
    alu_result = 0; alu_out = 0; mem_rdata = 0;
    #12;
    check("rst_s", 32'(s), 0);
    check("rst_pc", pc, RST_PC);
    check("rst_ir", ir, 0);
    check("rst_instret", instret, 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_bad", 32'(bad_state), 0);
    reset = 0;

    // R-type: fetch, decode, execute, rcomplete
    ns = 1; irw = 1; pcw = 1; pcs = 2'b00; alu_result = 32'h4; mem_rdata = 32'h0128_4020;
    tick();
    check("rt_s1", 32'(s), 1);
    check("rt_ir", ir, 32'h0128_4020);
    check("rt_op", 32'(op), 0);
    check("rt_pc", pc, 32'h4);
    idle_ctrl(); ns = 6;
    tick(); check("rt_s6", 32'(s), 6);
    ns = 7;
    tick(); check("rt_s7", 32'(s), 7);
    check("rt_instret0", instret, 0);
    ns = 0;
    tick(); check("rt_s0", 32'(s), 0);
    check("rt_instret1", instret, 1);

    // Memory stall on fetch
    ns = 1; irw = 1; pcw = 1; alu_result = 32'h8; mem_rdata = 32'h8C00_0000; mr = 1; mem_ready = 0;
    #1 check("stall_comb", 32'(stall), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_s", 32'(s), 0);
      check("stall_pc", pc, 32'h4);
      check("stall_ir", ir, 32'h0128_4020);
    end
    check("stall_cnt3", 32'(stall_cnt), 3);
    mem_ready = 1;
    #1 check("stall_release", 32'(stall), 0);
    tick();
    check("mem_s", 32'(s), 1);
    check("mem_ir", ir, 32'h8C00_0000);
    check("mem_pc", pc, 32'h8);
    check("mem_stall_cnt", 32'(stall_cnt), 3);
    idle_ctrl();

    // Branch taken
    ns = 8; tick(); check("br_s8", 32'(s), 8);
    pcwc = 1; pcs = 2'b01; alu_out = 32'h100; zero = 1; ns = 0;
    tick();
    check("br_taken_pc", pc, 32'h100);
    check("br_instret", instret, 2);
    idle_ctrl();
    // Branch not taken
    ns = 1; tick();
    ns = 8; tick(); check("br2_s8", 32'(s), 8);
    pcwc = 1; pcs = 2'b01; alu_out = 32'h200; zero = 0; ns = 0;
    tick();
    check("br_not_taken_pc", pc, 32'h100);
    check("br2_instret", instret, 3);
    idle_ctrl();

    // Jump
    ns = 1; irw = 1; mem_rdata = 32'h0800_0010; pcw = 1; pcs = 2'b00; alu_result = 32'h4000_0004;
    tick();
    check("jmp_ir", ir, 32'h0800_0010);
    check("jmp_pc_pre", pc, 32'h4000_0004);
    idle_ctrl(); ns = 9;
    tick(); check("jmp_s9", 32'(s), 9);
    pcw = 1; pcs = 2'b10; ns = 0;
    tick();
    check("jmp_pc", pc, 32'h4000_0040);
    check("jmp_instret", instret, 4);
    // pcs=11 suppresses the write
    pcw = 1; pcs = 2'b11; alu_result = 32'h0; ns = 1;
    tick();
    check("pcs11_pc", pc, 32'h4000_0040);
    check("pcs11_s", 32'(s), 1);

    // Reach state 4 with pc=0x40, then reset mid-cycle
    pcw = 1; pcs = 2'b00; alu_result = 32'h40; ns = 2;
    tick(); check("pre_rst_pc", pc, 32'h40);
    idle_ctrl(); ns = 3; tick();
    ns = 4; tick(); check("pre_rst_s4", 32'(s), 4);
    reset = 1;
    #1;
    check("mid_rst_s", 32'(s), 0);
    check("mid_rst_pc", pc, RST_PC);
    check("mid_rst_ir", ir, 0);
    check("mid_rst_op", 32'(op), 0);
    check("mid_rst_instret", instret, 0);
    check("mid_rst_stall_cnt", 32'(stall_cnt), 0);
    tick();
    reset = 0; ns = 0;

    // Illegal next state
    ns = 1; tick(); check("ill_s1", 32'(s), 1);
    ns = 12; tick();
    check("ill_s", 32'(s), 0);
    check("ill_bad", 32'(bad_state), 1);
    check("ill_instret", instret, 1);
    ns = 2; tick();
    check("ill_s2", 32'(s), 2);
    check("ill_bad_sticky", 32'(bad_state), 1);

    // instret wrap
    force dut.instret = 32'hFFFF_FFFF;
    #1 release dut.instret;
    ns = 0; tick();
    check("wrap_instret", instret, 0);
    check("wrap_s", 32'(s), 0);

    reset = 1; #1;
    check("rst_clears_bad", 32'(bad_state), 0);
    reset = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_state_sequencer.md
# mc_state_sequencer

Registered sequencing stage of the multicycle CPU control path. It consumes the control PLA's next-state and register-write outputs and owns the architectural state they act on: state register, instruction register and program counter. It feeds the current state `s` and opcode `op` back into the PLA. It also stalls the machine on memory wait states and counts retired instructions.

## Interface
Parameters:
- `WIDTH`, 32: PC, IR and datapath word width (must be 32 for jump-target formation).
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `ns`, in, 4: next state from control PLA.
- `pcw`, in, 1: unconditional PC write.
- `pcwc`, in, 1: conditional PC write (branch), qualified by `zero`.
- `pcs`, in, 2: PC source select.
- `irw`, in, 1: instruction register write.
- `mr`, in, 1: memory read in progress this cycle.
- `mw`, in, 1: memory write in progress this cycle.
- `mem_ready`, in, 1: memory completes access this cycle.
- `zero`, in, 1: ALU zero flag.
- `alu_result`, in, WIDTH: combinational ALU output.
- `alu_out`, in, WIDTH: registered ALUOut.
- `mem_rdata`, in, WIDTH: memory read data.
- `s`, out, 4: current control state, to PLA.
- `op`, out, 6: `ir[31:26]`, to PLA.
- `ir`, out, WIDTH: instruction register.
- `pc`, out, WIDTH: program counter.
- `stall`, out, 1: machine frozen this cycle.
- `instret`, out, 32: retired-instruction counter.
- `stall_cnt`, out, 16: saturating stall-cycle counter.
- `bad_state`, out, 1: sticky illegal-next-state flag.

## Operation
- `stall = (mr | mw) & ~mem_ready`. This is combinational and depends only on inputs, so no loop forms: the PLA depends only on registered `s` and `op`.
- `pc_en = pcw | (pcwc & zero)`.
- PC next-value mux:
  - `pcs=00`: `alu_result`.
  - `pcs=01`: `alu_out`.
  - `pcs=10`: `{pc[31:28], ir[25:0], 2'b00}`, using the pre-edge `pc`/`ir`.
  - `pcs=11`: no write, even if `pc_en`.
- Legal states are 0–9: fetch, decode, memaddr, memread, writeback, memwrite, execute, rcomplete, branch, jump.
- On each rising edge with `stall=0`:
  - `s <= ns` if `ns <= 9`. Otherwise `s <= 0` and `bad_state <= 1` (sticky until reset).
  - If `irw`: `ir <= mem_rdata`.
  - If `pc_en` and `pcs != 11`: `pc <=` mux output.
  - If `s != 0` and the committed next state is 0: `instret <= instret + 1`, wrapping modulo 2^32.
- On each rising edge with `stall=1`:
  - `s`, `ir`, `pc`, `instret` and `bad_state` hold.
  - `stall_cnt` increments and saturates at 16'hFFFF.
- Simultaneous `irw` and `pc_en` (fetch state): both commit on the same edge. The jump target uses the old `ir`.
- Reset (asynchronous, valid mid-instruction or mid-stall), all outputs take these values immediately:
  - `s=0`, `ir=0`, `op=0`, `pc=RESET_PC`.
  - `instret=0`, `stall_cnt=0`, `bad_state=0`.
  - `stall` follows its inputs combinationally.

## Timing
- Latency from `ns` to `s` is 1 cycle. Latency from `irw`/`pc_en` to `ir`/`pc` is 1 cycle.
- `op` tracks `ir` with no added delay.
- `stall` has zero latency from `mem_ready`. A memory access of N wait cycles holds `s` for N extra edges. The edge where `mem_ready=1` commits normally.
- Reset deassertion is synchronous to use: the first commit happens on the first rising edge with `reset=0`.
- `instret` updates on the same edge that `s` returns to 0.

## Test plan
- **Reset:** assert `reset` mid-state-4 with `pc=0x40`. Required: `s=0`, `pc=RESET_PC`, `ir=0`, `instret=0` immediately, before any clock edge.
- **R-type sequence:** drive `ns` 1→6→7→0, with fetch `irw=1`, `pcw=1`, `pcs=00`, `alu_result=0x4`, `mem_rdata=0x0128_4020`. Required:
  - `ir=0x01284020` and `op=0` after the first edge.
  - `pc=0x4`.
  - `instret` increments to 1 on the 7→0 edge.
- **Memory stall:** fetch with `mr=1` and `mem_ready` low for 3 cycles, then high. Required:
  - `s`, `pc` and `ir` hold for 3 edges.
  - `stall_cnt=3`.
  - `ir` loads on the 4th edge.
- **Branch:**
  - State 8 with `pcwc=1`, `pcs=01`, `alu_out=0x100`, `zero=1`: required `pc=0x100`.
  - Repeat with `zero=0`: required `pc` unchanged.
- **Jump:** `ir=0x0800_0010`, `pc=0x4000_0004`, state 9 with `pcw=1`, `pcs=10`. Required: `pc=0x4000_0040`.
- **Illegal state and wrap:**
  - `ns=12`: required `s=0`, `bad_state=1`, held until reset.
  - Preload `instret=0xFFFF_FFFF` and retire one instruction: required `instret=0`.
